// File: rtl/secuenciador_dispensado.sv
// Timed drink dispense sequencer: latches the decoded mode on start and steps
// water -> coffee -> optional milk, reporting busy/done/err to the panel.
module secuenciador_dispensado #(
    parameter int T_AGUA  = 8,
    parameter int T_CAFE  = 4,
    parameter int T_LECHE = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic cancel,
    input  logic M1,
    input  logic M0,
    output logic valvula_agua,
    output logic motor_cafe,
    output logic valvula_leche,
    output logic busy,
    output logic done,
    output logic err,
    output logic sin_leche
);

    localparam int T_MAX_AC = (T_AGUA > T_CAFE) ? T_AGUA : T_CAFE;
    localparam int T_MAX    = (T_MAX_AC > T_LECHE) ? T_MAX_AC : T_LECHE;
    localparam int CNT_W    = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0] CARGA_AGUA  = CNT_W'(T_AGUA - 1);
    localparam logic [CNT_W-1:0] CARGA_CAFE  = CNT_W'(T_CAFE - 1);
    localparam logic [CNT_W-1:0] CARGA_LECHE = CNT_W'(T_LECHE - 1);

    typedef enum logic [2:0] {
        IDLE,
        AGUA,
        CAFE,
        LECHE,
        FIN,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        MODO_NADA      = 2'b00,
        MODO_SOLO      = 2'b01,
        MODO_SIN_LECHE = 2'b10,
        MODO_CON_LECHE = 2'b11
    } modo_t;

    state_t           state_q, state_d;
    modo_t            modo_q, modo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_cero;
    logic             busy_d;

    assign cnt_cero = (cnt_q == '0);
    assign busy_d   = (state_d == AGUA) || (state_d == CAFE) || (state_d == LECHE);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        modo_d  = modo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    if ({M1, M0} != 2'b00) begin
                        modo_d  = modo_t'({M1, M0});
                        cnt_d   = CARGA_AGUA;
                        state_d = AGUA;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            AGUA: begin
                if (cancel) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_cero) begin
                    cnt_d   = CARGA_CAFE;
                    state_d = CAFE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CAFE: begin
                if (cancel) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_cero) begin
                    if (modo_q == MODO_CON_LECHE) begin
                        cnt_d   = CARGA_LECHE;
                        state_d = LECHE;
                    end else begin
                        state_d = FIN;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LECHE: begin
                if (cancel) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_cero) begin
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // FIN and ERR last one cycle; start is deliberately not looked at here.
            FIN:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered decodes of the next state, so they line up with
    // state_q and never see an input combinationally.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            modo_q        <= MODO_NADA;
            cnt_q         <= '0;
            valvula_agua  <= 1'b0;
            motor_cafe    <= 1'b0;
            valvula_leche <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            sin_leche     <= 1'b0;
        end else begin
            state_q       <= state_d;
            modo_q        <= modo_d;
            cnt_q         <= cnt_d;
            valvula_agua  <= (state_d == AGUA);
            motor_cafe    <= (state_d == CAFE);
            valvula_leche <= (state_d == LECHE);
            busy          <= busy_d;
            done          <= (state_d == FIN);
            err           <= (state_d == ERR);
            sin_leche     <= busy_d && (modo_d == MODO_SIN_LECHE);
        end
    end

endmodule

// File: tb/tb_secuenciador_dispensado.sv
// Self-checking bench for secuenciador_dispensado: directed scenarios plus
// random traffic against a timeline-based reference model.
module tb_secuenciador_dispensado;

    localparam int TA = 8;
    localparam int TC = 4;
    localparam int TL = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic cancel = 1'b0;
    logic M1 = 1'b0;
    logic M0 = 1'b0;
    logic valvula_agua, motor_cafe, valvula_leche, busy, done, err, sin_leche;

    secuenciador_dispensado #(
        .T_AGUA (TA),
        .T_CAFE (TC),
        .T_LECHE(TL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cancel       (cancel),
        .M1           (M1),
        .M0           (M0),
        .valvula_agua (valvula_agua),
        .motor_cafe   (motor_cafe),
        .valvula_leche(valvula_leche),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .sin_leche    (sin_leche)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a drink is a timeline of m_len busy cycles measured
    // from the start edge, followed by a single done cycle.
    bit         m_act  = 1'b0;
    bit         m_err  = 1'b0;
    int         m_e    = 0;
    int         m_len  = 0;
    logic [1:0] m_mode = 2'b00;

    int cyc = 0;
    int start_cyc, done_cyc;
    int n_agua, n_cafe, n_leche, n_busy, n_done, n_err, n_sinl;

    task automatic model_step();
        if (reset) begin
            m_act = 1'b0;
            m_err = 1'b0;
        end else if (m_err) begin
            m_err = 1'b0;
        end else if (m_act) begin
            if (m_e < m_len && cancel) m_act = 1'b0;
            else if (m_e == m_len)     m_act = 1'b0;
            else                       m_e++;
        end else if (start && !cancel) begin
            if ({M1, M0} != 2'b00) begin
                m_act  = 1'b1;
                m_e    = 0;
                m_mode = {M1, M0};
                m_len  = TA + TC + ((m_mode == 2'b11) ? TL : 0);
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic compare_outputs();
        logic e_busy;
        e_busy = m_act && (m_e < m_len);
        check("busy",          busy,          e_busy);
        check("valvula_agua",  valvula_agua,  e_busy && (m_e < TA));
        check("motor_cafe",    motor_cafe,    e_busy && (m_e >= TA) && (m_e < TA + TC));
        check("valvula_leche", valvula_leche, e_busy && (m_e >= TA + TC));
        check("done",          done,          m_act && (m_e == m_len));
        check("err",           err,           m_err);
        check("sin_leche",     sin_leche,     e_busy && (m_mode == 2'b10));
        check("exclusive", ((32'(valvula_agua) + 32'(motor_cafe) + 32'(valvula_leche)) <= 1), 1);
        n_agua  += int'(valvula_agua);
        n_cafe  += int'(motor_cafe);
        n_leche += int'(valvula_leche);
        n_busy  += int'(busy);
        n_done  += int'(done);
        n_err   += int'(err);
        n_sinl  += int'(sin_leche);
        if (done) done_cyc = cyc;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic clear_counts();
        n_agua = 0; n_cafe = 0; n_leche = 0; n_busy = 0;
        n_done = 0; n_err = 0; n_sinl = 0; done_cyc = -1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_agua"},  valvula_agua,  1'b0);
        check({tag, "_cafe"},  motor_cafe,    1'b0);
        check({tag, "_leche"}, valvula_leche, 1'b0);
        check({tag, "_busy"},  busy,          1'b0);
        check({tag, "_done"},  done,          1'b0);
        check({tag, "_err"},   err,           1'b0);
        check({tag, "_sinl"},  sin_leche,     1'b0);
    endtask

    // One complete drink from a start pulse, checked against the stage lengths.
    task automatic run_seq(input logic [1:0] mode, input string tag);
        int len;
        len = TA + TC + ((mode == 2'b11) ? TL : 0);
        {M1, M0} = mode;
        start = 1'b1;
        clear_counts();
        tick();
        start_cyc = cyc;
        start = 1'b0;
        repeat (len + 4) tick();
        check({tag, "_agua_cycles"},  n_agua,  TA);
        check({tag, "_cafe_cycles"},  n_cafe,  TC);
        check({tag, "_leche_cycles"}, n_leche, (mode == 2'b11) ? TL : 0);
        check({tag, "_busy_cycles"},  n_busy,  len);
        check({tag, "_done_pulses"},  n_done,  1);
        check({tag, "_done_delay"},   done_cyc - start_cyc, len);
        check({tag, "_sinl_cycles"},  n_sinl,  (mode == 2'b10) ? len : 0);
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) tick();

        run_seq(2'b01, "m01");
        run_seq(2'b11, "m11");
        run_seq(2'b10, "m10");

        // Empty mode: a single err pulse and nothing else.
        {M1, M0} = 2'b00;
        start = 1'b1;
        clear_counts();
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("m00_err_pulses", n_err, 1);
        check("m00_busy", n_busy, 0);
        check("m00_done", n_done, 0);
        check("m00_actuators", n_agua + n_cafe + n_leche, 0);

        // Cancel on the third coffee cycle of a mode-11 drink.
        {M1, M0} = 2'b11;
        start = 1'b1;
        clear_counts();
        tick();
        start = 1'b0;
        repeat (TA + 2) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_cafe_drop", motor_cafe, 1'b0);
        repeat (TL + 6) tick();
        check("cancel_cafe_cycles", n_cafe, 3);
        check("cancel_leche", n_leche, 0);
        check("cancel_done", n_done, 0);
        run_seq(2'b01, "after_cancel");

        // Mode change and extra start mid-sequence, then reset during milk.
        {M1, M0} = 2'b11;
        start = 1'b1;
        clear_counts();
        tick();
        start = 1'b0;
        repeat (3) tick();
        {M1, M0} = 2'b00;
        repeat (6) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("midseq_in_leche", valvula_leche, 1'b1);
        check("midseq_leche_cycles", n_leche, 3);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        m_act = 1'b0;
        m_err = 1'b0;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check("midseq_done", n_done, 0);
        check("midseq_err", n_err, 0);

        // Start held high: drinks run back to back, one per IDLE visit.
        {M1, M0} = 2'b01;
        start = 1'b1;
        repeat (45) tick();
        start = 1'b0;
        repeat (15) tick();

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            start    = ($urandom_range(3) == 0);
            cancel   = ($urandom_range(15) == 0);
            {M1, M0} = 2'($urandom_range(3));
            reset    = ($urandom_range(299) == 0);
            tick();
        end
        reset = 1'b0;
        start = 1'b0;
        cancel = 1'b0;
        repeat (25) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/secuenciador_dispensado.md
Name: secuenciador_dispensado

Overview:
- Downstream stage of the drink-request decoder: consumes the 2-bit mode code {M1,M0} and runs the timed dispense sequence (water, coffee, optional milk).
- Latches the mode on a start press, drives actuators for parameterised durations, and reports busy/done/error to the panel.
- Moore FSM plus one down-counter.

Parameters:
- T_AGUA, 8, cycles the water valve stays open (>=1)
- T_CAFE, 4, cycles the coffee motor runs (>=1)
- T_LECHE, 6, cycles the milk valve stays open (>=1)
- CNT_W, $clog2(max(T_AGUA,T_CAFE,T_LECHE)+1), counter width (derived, not overridden)

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high
- start  in  1  drink request, level-sampled each edge
- cancel  in  1  abort request
- M1  in  1  mode code MSB from the decoder
- M0  in  1  mode code LSB from the decoder
- valvula_agua  out  1  water valve drive
- motor_cafe  out  1  coffee motor drive
- valvula_leche  out  1  milk valve drive
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle rejected-request pulse
- sin_leche  out  1  milk requested but unavailable; black coffee being served

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk. Reset forces state IDLE, counter 0, latched mode 00, all outputs 0.
- Mode codes:
  - 00: no drink
  - 01: coffee, no milk wanted
  - 10: milk wanted but unavailable; serve black
  - 11: coffee with milk
- States: IDLE, AGUA, CAFE, LECHE, FIN, ERR. All outputs decode from registered state and latched mode only (Moore); no input-to-output combinational path.
- IDLE:
  - start=1, cancel=0, {M1,M0}!=00: latch mode, load counter with T_AGUA-1, go to AGUA.
  - start=1, cancel=0, {M1,M0}=00: go to ERR.
  - Otherwise stay in IDLE.
- AGUA: valvula_agua=1, busy=1. Counter decrements each cycle. At counter=0, load T_CAFE-1 and go to CAFE.
- CAFE: motor_cafe=1, busy=1. At counter=0:
  - latched mode 11: load T_LECHE-1, go to LECHE
  - otherwise: go to FIN
- LECHE: valvula_leche=1, busy=1. At counter=0, go to FIN.
- FIN: done=1, busy=0, actuators 0, for exactly one cycle, then IDLE. start is ignored in FIN.
- ERR: err=1, busy=0, for exactly one cycle, then IDLE.
- sin_leche = busy AND latched mode==10.
- Timing: each stage's actuator is high for exactly its T cycles. With start sampled at edge k, valvula_agua rises after edge k. done pulse is:
  - T_AGUA+T_CAFE cycles after edge k for modes 01/10
  - T_AGUA+T_CAFE+T_LECHE cycles after edge k for mode 11
- Actuator exclusivity: at most one of valvula_agua, motor_cafe, valvula_leche is high in any cycle.
- Mode is latched only at start. Changes on M1/M0 during a sequence are ignored.
- start while busy is ignored; there is no queueing.
- cancel:
  - Highest priority. cancel=1 at any edge in AGUA/CAFE/LECHE: go to IDLE next cycle, all actuators 0, no done, no err.
  - cancel in IDLE/FIN/ERR: no effect, except that cancel and start together in IDLE means nothing starts.
- Reset asserted mid-sequence: actuators drop immediately (asynchronously), no done.
- Holding start high continuously: a new sequence starts on the first IDLE edge after FIN. This is one drink per IDLE visit.
- Counter never wraps: it is reloaded on every stage entry and only decrements while nonzero.

Test Plan:
- Mode 01, start pulse at edge k, defaults: valvula_agua high 8 cycles, motor_cafe high 4 cycles, valvula_leche never high. done single pulse 12 cycles after k; busy high exactly 12 cycles.
- Mode 11, start: agua 8, cafe 4, leche 6 cycles back-to-back. done 18 cycles after k; sin_leche=0 throughout.
- Mode 10, start: same timing as mode 01; sin_leche=1 for all 12 busy cycles, 0 after.
- Mode 00, start: err=1 for exactly one cycle; busy, done and actuators stay 0.
- Mode 11 started, cancel=1 on 3rd cycle of CAFE: motor_cafe drops next cycle, no leche, no done. A following start with mode 01 runs a normal 12-cycle sequence.
- Mode changed 11->00 mid-AGUA, start re-pulsed mid-CAFE, then reset asserted during LECHE: sequence continues as mode 11 and the extra start is ignored; on reset, all outputs drop to 0 asynchronously and state is IDLE.
